// File: rtl/serial_mem_arbiter.sv
// Serial external-memory arbiter: fixed priority fetch > RAM write > RAM read, address then
// data shifted MSB first over one bit-serial link. SERIAL_PARITY_EN adds an even-parity bit.
module serial_mem_arbiter #(
  parameter int PC_W = 16,
  parameter int RA_W = 8
) (
  input  logic            sclk,
  input  logic            rst,
  input  logic            ready,
  input  logic            serial_in,
  output logic            serial_out,
  input  logic            fetch_req,
  input  logic [PC_W-1:0] fetch_addr,
  input  logic            ramw_req,
  input  logic [RA_W-1:0] ramw_addr,
  input  logic [7:0]      ramw_data,
  input  logic            ramr_req,
  input  logic [RA_W-1:0] ramr_addr,
  output logic [2:0]      gnt,
  output logic [7:0]      rdata,
  output logic            done,
  output logic            busy,
  output logic            pc_in_flag,
  output logic            rom_out_flag,
  output logic            ram_in_flag,
  output logic            ram_out_flag,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
`ifdef SERIAL_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rx;
  logic [7:0]  r_rdata;
  logic [2:0]  r_gnt;
  logic        w_any_req;
  logic        w_last;
  logic        w_data_phase;

  assign w_any_req = fetch_req | ramw_req | ramr_req;
  assign w_last    = (r_cnt == 5'd0);

  always_ff @(posedge sclk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output is defaulted first so no path through the case can infer a latch.
    w_next       = r_state;
    serial_out   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_data_phase = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = S_ADDR;
      S_ADDR: begin
        busy       = 1'b1;
        serial_out = r_addr[r_cnt];
        if (ready && w_last) w_next = S_DATA;
      end
      S_DATA: begin
        busy         = 1'b1;
        w_data_phase = 1'b1;
        serial_out   = r_gnt[1] & r_wdata[r_cnt[2:0]];
`ifdef SERIAL_PARITY_EN
        if (ready && w_last) w_next = S_PARITY;
`else
        if (ready && w_last) w_next = S_DONE;
`endif
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        busy         = 1'b1;
        w_data_phase = 1'b1;
        serial_out   = r_gnt[1] & (^r_wdata);
        if (ready) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant is held only while a transfer is on the link, so it doubles as the target flags.
  assign gnt          = r_gnt;
  assign rdata        = r_rdata;
  assign pc_in_flag   = r_gnt[0] & (r_state == S_ADDR);
  assign rom_out_flag = r_gnt[0] & w_data_phase;
  assign ram_in_flag  = r_gnt[1];
  assign ram_out_flag = r_gnt[2];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 5'd0;
      r_addr  <= 32'd0;
      r_wdata <= 8'd0;
      r_rx    <= 8'd0;
      r_rdata <= 8'd0;
      r_gnt   <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_req) begin
            r_gnt  <= 3'b001;
            r_addr <= 32'(fetch_addr);
            r_cnt  <= 5'(PC_W - 1);
          end else if (ramw_req) begin
            r_gnt   <= 3'b010;
            r_addr  <= 32'(ramw_addr);
            r_wdata <= ramw_data;
            r_cnt   <= 5'(RA_W - 1);
          end else if (ramr_req) begin
            r_gnt  <= 3'b100;
            r_addr <= 32'(ramr_addr);
            r_cnt  <= 5'(RA_W - 1);
          end
        end
        S_ADDR: begin
          if (ready) r_cnt <= w_last ? 5'd7 : r_cnt - 5'd1;
        end
        S_DATA: begin
          if (ready) begin
            r_rx <= {r_rx[6:0], serial_in};
            if (w_last) begin
`ifndef SERIAL_PARITY_EN
              if (!r_gnt[1]) r_rdata <= {r_rx[6:0], serial_in};
              r_gnt <= 3'b000;
`endif
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
`ifdef SERIAL_PARITY_EN
        S_PARITY: begin
          if (ready) begin
            if (!r_gnt[1]) r_rdata <= r_rx;
            r_gnt <= 3'b000;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SERIAL_PARITY_EN
  logic r_err;

  // Sticky: a bad parity bit on any read is remembered until reset.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if (r_state == S_PARITY && ready && !r_gnt[1] && (serial_in != (^r_rx))) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mem_arbiter.sv
// Self-checking bench for serial_mem_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level model of bit streams, latency, read data and flags.
module tb_serial_mem_arbiter;
  localparam int PC_W = 16;
  localparam int RA_W = 8;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic            sclk = 1'b0;
  logic            rst = 1'b1;
  logic            ready = 1'b0;
  logic            serial_in = 1'b0;
  logic            serial_out;
  logic            fetch_req = 1'b0;
  logic [PC_W-1:0] fetch_addr = '0;
  logic            ramw_req = 1'b0;
  logic [RA_W-1:0] ramw_addr = '0;
  logic [7:0]      ramw_data = '0;
  logic            ramr_req = 1'b0;
  logic [RA_W-1:0] ramr_addr = '0;
  logic [2:0]      gnt;
  logic [7:0]      rdata;
  logic            done;
  logic            busy;
  logic            pc_in_flag;
  logic            rom_out_flag;
  logic            ram_in_flag;
  logic            ram_out_flag;
  logic            err;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic       exp_err = 1'b0;

  always #5 sclk = ~sclk;

  serial_mem_arbiter #(.PC_W(PC_W), .RA_W(RA_W)) dut (
    .sclk(sclk), .rst(rst), .ready(ready), .serial_in(serial_in), .serial_out(serial_out),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .ramw_req(ramw_req), .ramw_addr(ramw_addr), .ramw_data(ramw_data),
    .ramr_req(ramr_req), .ramr_addr(ramr_addr),
    .gnt(gnt), .rdata(rdata), .done(done), .busy(busy),
    .pc_in_flag(pc_in_flag), .rom_out_flag(rom_out_flag),
    .ram_in_flag(ram_in_flag), .ram_out_flag(ram_out_flag), .err(err)
  );

  task automatic set_req(input int kind, input logic [31:0] addr, input logic [7:0] wd);
    case (kind)
      0: begin fetch_req = 1'b1; fetch_addr = addr[PC_W-1:0]; end
      1: begin ramw_req = 1'b1; ramw_addr = addr[RA_W-1:0]; ramw_data = wd; end
      default: begin ramr_req = 1'b1; ramr_addr = addr[RA_W-1:0]; end
    endcase
  endtask

  // Requester releases its line; address/data are scrambled to prove they were latched.
  task automatic drop_req(input int kind);
    case (kind)
      0: begin fetch_req = 1'b0; fetch_addr = PC_W'($urandom); end
      1: begin ramw_req = 1'b0; ramw_addr = RA_W'($urandom); ramw_data = 8'($urandom); end
      default: begin ramr_req = 1'b0; ramr_addr = RA_W'($urandom); end
    endcase
  endtask

  // Called at a negedge with the DUT idle and this kind's request winning at the next edge.
  task automatic run_transfer(input string name, input int kind, input logic [31:0] addr,
                              input logic [7:0] wd, input logic [7:0] rx, input bit bad_par,
                              input int rmode, input bit drop_mid, input int edge_req);
    int aw, nbits, consumed, e, waited, early_done, flag_err, got_edge, exp_edge, bad_idx;
    logic [2:0] gnt_exp;
    logic [3:0] flags_exp;
    bit exp_bits[$];
    bit got_bits[$];
    aw = (kind == 0) ? PC_W : RA_W;
    nbits = aw + 8 + PAR;
    gnt_exp = 3'b001 << kind;
    for (int i = aw - 1; i >= 0; i--) exp_bits.push_back(addr[i]);
    for (int i = 7; i >= 0; i--) exp_bits.push_back((kind == 1) ? wd[i] : 1'b0);
    if (PAR == 1) exp_bits.push_back((kind == 1) ? (^wd) : 1'b0);
    consumed = 0; early_done = 0; flag_err = 0; waited = 0;

    ready = 1'b1;
    serial_in = 1'b0;
    @(posedge sclk);
    e = 1;
    @(negedge sclk);
    n_checks++;
    if (gnt !== gnt_exp) $display("FAIL %s_gnt: got %b expected %b", name, gnt, gnt_exp);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b expected 1", name, busy);
    else n_pass++;

    while (consumed < nbits && e < 400) begin
      if (done === 1'b1) early_done++;
      e++;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = e[0];
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
      serial_in = 1'($urandom_range(0, 1));
      if (ready) begin
        got_bits.push_back(serial_out);
        flags_exp = {kind == 0 && consumed < aw, kind == 0 && consumed >= aw, kind == 1, kind == 2};
        if ({pc_in_flag, rom_out_flag, ram_in_flag, ram_out_flag} !== flags_exp || gnt !== gnt_exp)
          flag_err++;
        if (kind != 1 && consumed >= aw && consumed < aw + 8) serial_in = rx[7 - (consumed - aw)];
        else if (kind != 1 && consumed == aw + 8) serial_in = (^rx) ^ bad_par;
        consumed++;
      end
      if (drop_mid && consumed == 2) drop_req(kind);
      @(posedge sclk);
      @(negedge sclk);
    end
    while (done !== 1'b1 && waited < 4) begin
      ready = 1'b1;
      @(posedge sclk);
      @(negedge sclk);
      waited++;
    end
    got_edge = e + 1 + waited;
    exp_edge = (edge_req != 0) ? edge_req : e + 1;
    if (kind != 1) exp_rdata = rx;
    if (PAR == 1 && kind != 1 && bad_par) exp_err = 1'b1;

    n_checks++;
    if (done !== 1'b1 || got_edge != exp_edge)
      $display("FAIL %s_done_edge: got done=%b at edge %0d expected edge %0d", name, done, got_edge, exp_edge);
    else n_pass++;
    n_checks++;
    if (early_done != 0 || flag_err != 0)
      $display("FAIL %s_flags: got %0d early done, %0d flag/gnt errors expected 0", name, early_done, flag_err);
    else n_pass++;
    bad_idx = -1;
    for (int i = 0; i < nbits; i++)
      if (bad_idx < 0 && (i >= got_bits.size() || got_bits[i] != exp_bits[i])) bad_idx = i;
    n_checks++;
    if (bad_idx >= 0)
      $display("FAIL %s_serial_out: bit %0d got %0d expected %0d (%0d bits captured)", name, bad_idx,
               (bad_idx < got_bits.size()) ? int'(got_bits[bad_idx]) : -1, int'(exp_bits[bad_idx]), got_bits.size());
    else n_pass++;
    n_checks++;
    if (rdata !== exp_rdata) $display("FAIL %s_rdata: got %h expected %h", name, rdata, exp_rdata);
    else n_pass++;
    n_checks++;
    if ({gnt, busy, serial_out} !== 5'b0)
      $display("FAIL %s_done_cycle: got gnt=%b busy=%b serial_out=%b expected 000/0/0", name, gnt, busy, serial_out);
    else n_pass++;
    n_checks++;
    if (err !== exp_err) $display("FAIL %s_err: got %b expected %b", name, err, exp_err);
    else n_pass++;

    drop_req(kind);
    @(posedge sclk);
    @(negedge sclk);
    n_checks++;
    if ({done, busy, gnt} !== 5'b0)
      $display("FAIL %s_idle: got done=%b busy=%b gnt=%b expected 0/0/000", name, done, busy, gnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge sclk);
    n_checks++;
    if ({serial_out, gnt, rdata, done, busy} !== 14'b0)
      $display("FAIL reset_outputs: got so=%b gnt=%b rdata=%h done=%b busy=%b expected all 0",
               serial_out, gnt, rdata, done, busy);
    else n_pass++;
    n_checks++;
    if ({pc_in_flag, rom_out_flag, ram_in_flag, ram_out_flag, err} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {pc_in_flag, rom_out_flag, ram_in_flag, ram_out_flag, err});
    else n_pass++;
    rst = 1'b0;
    @(negedge sclk);
    n_checks++;
    if ({busy, gnt} !== 4'b0) $display("FAIL reset_idle: got busy=%b gnt=%b expected 0/000", busy, gnt);
    else n_pass++;
  endtask

  task automatic test_fetch_directed();
    set_req(0, 32'h1234, 8'h00);
    run_transfer("fetch_dir", 0, 32'h1234, 8'h00, 8'hA5, 1'b0, 0, 1'b0, 26 + PAR);
  endtask

  task automatic test_ramw_directed();
    set_req(1, 32'h7F, 8'h3C);
    run_transfer("ramw_dir", 1, 32'h7F, 8'h3C, 8'h00, 1'b0, 1, 1'b0, 34 + 2 * PAR);
  endtask

  task automatic test_priority();
    logic [31:0] a0, a1, a2;
    logic [7:0] w1, r0, r2;
    a0 = $urandom; a1 = $urandom; a2 = $urandom;
    w1 = 8'($urandom); r0 = 8'($urandom); r2 = 8'($urandom);
    set_req(0, a0, 8'h00);
    set_req(1, a1, w1);
    set_req(2, a2, 8'h00);
    run_transfer("prio_fetch", 0, a0, 8'h00, r0, 1'b0, 0, 1'b0, 0);
    run_transfer("prio_ramw", 1, a1, w1, 8'h00, 1'b0, 0, 1'b0, 0);
    run_transfer("prio_ramr", 2, a2, 8'h00, r2, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset_midway();
    int dones;
    set_req(2, 32'h5A, 8'h00);
    ready = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    repeat (5) begin
      @(posedge sclk);
      @(negedge sclk);
    end
    n_checks++;
    if (ram_out_flag !== 1'b1) $display("FAIL midrst_active: got ram_out_flag=%b expected 1", ram_out_flag);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, gnt, done, serial_out, ram_out_flag, rdata} !== 15'b0)
      $display("FAIL midrst_async: got busy=%b gnt=%b done=%b so=%b flag=%b rdata=%h expected all 0",
               busy, gnt, done, serial_out, ram_out_flag, rdata);
    else n_pass++;
    ramr_req = 1'b0;
    dones = 0;
    repeat (3) begin
      @(posedge sclk);
      @(negedge sclk);
      if (done === 1'b1) dones++;
    end
    rst = 1'b0;
    exp_rdata = 8'h00;
    exp_err = 1'b0;
    @(negedge sclk);
    if (done === 1'b1) dones++;
    n_checks++;
    if (dones != 0 || busy !== 1'b0) $display("FAIL midrst_nodone: got %0d done pulses busy=%b expected 0/0", dones, busy);
    else n_pass++;
    set_req(2, 32'hC3, 8'h00);
    run_transfer("midrst_new", 2, 32'hC3, 8'h00, 8'h96, 1'b0, 0, 1'b0, 18 + PAR);
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] addr;
    logic [7:0] wd, rx;
    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      wd = 8'($urandom);
      rx = 8'($urandom);
      set_req(kind, addr, wd);
      run_transfer("rand", kind, addr, wd, rx, 1'b0, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    set_req(2, 32'h21, 8'h00);
    run_transfer("par_bad", 2, 32'h21, 8'h00, 8'h01, 1'b1, 0, 1'b0, 19);
    set_req(1, 32'h44, 8'hE7);
    run_transfer("par_ramw", 1, 32'h44, 8'hE7, 8'h00, 1'b0, 2, 1'b0, 0);
    set_req(2, 32'h90, 8'h00);
    run_transfer("par_sticky", 2, 32'h90, 8'h00, 8'h6B, 1'b0, 0, 1'b0, 19);
    rst = 1'b1;
    #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL par_clear: got err=%b expected 0", err);
    else n_pass++;
    @(negedge sclk);
    rst = 1'b0;
    exp_err = 1'b0;
    exp_rdata = 8'h00;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_directed();
    test_ramw_directed();
    test_priority();
    test_reset_midway();
    test_random();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
